mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Sequential signed multiply/divide unit for the single-bus CPU datapath. It sits beside the ALU, downstream of the Y register and the bus. It takes operand A from Y and operand B from BusMuxOut, then returns a 64-bit result split into high and low words. The control sequencer loads these into Z_HI and Z_LO when `done` pulses. MUL uses radix-2 Booth; DIV uses signed non-restoring division on magnitudes with a sign fix-up.

## Interface
- `WIDTH`, 32, operand/result word width
- `clk`  in  1  rising-edge clock
- `clr`  in  1  reset, synchronous, active-high
- `start`  in  1  request; sampled only when not busy
- `op`  in  1  0 = MUL, 1 = DIV
- `a`  in  WIDTH  multiplicand / dividend (from Y)
- `b`  in  WIDTH  multiplier / divisor (from BusMuxOut)
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; results valid from this cycle
- `result_hi`  out  WIDTH  MUL: product[63:32]; DIV: remainder
- `result_lo`  out  WIDTH  MUL: product[31:0]; DIV: quotient
- `div_by_zero`  out  1  set with `done` when DIV had b == 0; held until next accepted start

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 latches `a`, `b`, `op` and goes to CALC.
  - DIV with `b`=0: go straight to FIX.
  - CALC: one iteration per cycle, 5-bit counter 0..31; after count 31 go to FIX.
  - FIX: apply signs, write the result registers, pulse `done`, return to IDLE.
- MUL: Booth radix-2 on a 65-bit {A-acc, Q, q-1} register with an arithmetic right shift each iteration. The full signed 64-bit product is exact, with no overflow.
- DIV:
  - Operate on |a| and |b|, where |0x80000000| is treated as unsigned 2^31.
  - Quotient truncates toward zero and is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of `a`.
  - A non-restoring final correction step is folded into FIX.
- Divide by zero: `result_lo`=32'hFFFFFFFF, `result_hi`=`a`, `div_by_zero`=1.
- Overflow case 0x80000000 / -1: quotient wraps to 0x80000000, remainder 0, no flag.
- `result_hi`/`result_lo` hold their values until the FIX of the next accepted operation. They are not cleared at start.
- `start` while `busy`=1 is ignored; no queuing.
- `start` in the same cycle as `done`=1 is accepted, because the state is already IDLE.
- `op`, `a` and `b` are don't-care except at the accepting edge.

## Timing
- Reset values after any edge with `clr`=1: state IDLE, `busy`=0, `done`=0, `result_hi`=0, `result_lo`=0, `div_by_zero`=0, counter 0.
- `clr` overrides `start` in the same cycle.
- `clr` mid-operation aborts with no `done` pulse.
- Normal latency: `start` sampled at edge E0.
  - `busy`=1 after E0.
  - CALC occupies edges E1..E32.
  - FIX at E33 gives `done`=1, results valid, and `busy`=0 after E33.
  - `done` drops at E34.
  - Throughput is one operation per 34 cycles.
- Divide-by-zero latency: `start` at E0 gives `done`=1 after E1, with `busy`=1 only for the cycle between E0 and E1.
- `busy` and `done` are never high together.

## Structure
- Shared CPU package holds:
  - op encoding `MD_OP_MUL`=1'b0, `MD_OP_DIV`=1'b1
  - state enum {IDLE, CALC, FIX}
  - `WIDTH` default constant
- One sub-module, `md_addsub`: a (WIDTH+1)-bit adder/subtractor with a `sub` control. It is shared by the Booth add/subtract and the non-restoring divide step, so only one carry chain is instantiated.
- The FSM, counter, shift registers and sign fix-up stay in `mul_div_unit`.

## Test plan
- MUL, a=7, b=-3 (0xFFFFFFFD) → after 34 cycles `done`=1, `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFEB, `div_by_zero`=0.
- MUL, a=b=0x80000000 → `result_hi`=0x40000000, `result_lo`=0x00000000. Then MUL 0x7FFFFFFF×0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- DIV, a=-7, b=2 → `result_lo`=0xFFFFFFFD (-3), `result_hi`=0xFFFFFFFF (-1). Also DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIV, a=100, b=0 → `done` one edge after acceptance, `div_by_zero`=1, lo=0xFFFFFFFF, hi=0x64. Next start clears the flag.
- DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_by_zero`=0, normal 34-cycle latency.
- Control edge cases:
  - `start` pulsed at cycle 5 of a MUL is ignored, and the original result is unchanged.
  - `clr` at cycle 10 gives `busy`=0 and zeroed outputs after that edge, and no `done` ever.
  - Back-to-back `start` asserted with `done` is accepted.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the sequential multiply/divide unit beside the ALU.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control sequencer (master) and the mul/div unit (slave).
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, div_by_zero
    );

endinterface

// File: rtl/md_addsub.sv
// Single (N)-bit carry chain shared by the Booth add/subtract and the divide step.
module md_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] sum
);

    // Subtraction as x + ~y + 1 keeps a single adder.
    assign sum = x + (y ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring on magnitudes).
//   state | meaning
//   IDLE  | waiting for start; busy low
//   CALC  | one Booth or divide iteration per cycle, cnt 0..31
//   FIX   | remainder correction, sign fix-up, results written, done pulsed
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic           clk,
    input  logic           clr,
    mul_div_unit_if.slave  bus
);

    md_state_e        state, state_nxt;
    logic [4:0]       cnt;
    logic             op_r, neg_q, neg_r, dbz_pend, q_m1;
    logic [WIDTH:0]   acc, m, acc_n, add_x, add_y, sum;
    logic [WIDTH-1:0] q, a_r, rem_mag, a_mag, b_mag;
    logic             add_sub, booth_add;
    logic             done_r, dbz_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    md_addsub #(.N(WIDTH + 1)) u_addsub (
        .x   (add_x),
        .y   (add_y),
        .sub (add_sub),
        .sum (sum)
    );

    assign a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start)
                      state_nxt = (bus.op == MD_OP_DIV && bus.b == '0) ? FIX : CALC;
            CALC: if (cnt == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.done        = done_r;
        bus.result_hi   = hi_r;
        bus.result_lo   = lo_r;
        bus.div_by_zero = dbz_r;
    end

    // Divide: shift-then-add/sub driven by the partial remainder sign; in FIX the
    // same adder restores a negative remainder.
    always_comb begin
        add_x   = acc;
        add_y   = m;
        add_sub = 1'b0;
        if (op_r == MD_OP_DIV) begin
            if (state == CALC) begin
                add_x   = {acc[WIDTH-1:0], q[WIDTH-1]};
                add_sub = ~acc[WIDTH];
            end
        end else begin
            add_sub = q[0] & ~q_m1;
        end
    end

    assign booth_add = q[0] ^ q_m1;
    assign acc_n     = booth_add ? sum : acc;
    assign rem_mag   = acc[WIDTH] ? sum[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt      <= '0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            op_r     <= MD_OP_MUL;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            a_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    op_r     <= bus.op;
                    a_r      <= bus.a;
                    acc      <= '0;
                    q_m1     <= 1'b0;
                    cnt      <= '0;
                    dbz_r    <= 1'b0;
                    neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_r    <= bus.a[WIDTH-1];
                    dbz_pend <= (bus.op == MD_OP_DIV) && (bus.b == '0);
                    if (bus.op == MD_OP_DIV) begin
                        q <= a_mag;
                        m <= {1'b0, b_mag};
                    end else begin
                        q <= bus.b;
                        m <= {bus.a[WIDTH-1], bus.a};
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_r == MD_OP_DIV) begin
                        acc <= sum;
                        q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
                    end else begin
                        acc  <= {acc_n[WIDTH], acc_n[WIDTH:1]};
                        q    <= {acc_n[0], q[WIDTH-1:1]};
                        q_m1 <= q[0];
                    end
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (dbz_pend) begin
                        dbz_r <= 1'b1;
                        hi_r  <= a_r;
                        lo_r  <= '1;
                    end else if (op_r == MD_OP_DIV) begin
                        hi_r <= neg_r ? -rem_mag : rem_mag;
                        lo_r <= neg_q ? -q : q;
                    end else begin
                        hi_r <= acc[WIDTH-1:0];
                        lo_r <= q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: table of operations plus control-path sequences.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    localparam int NV = 14;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[NV];

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive a request across its accepting edge, then scramble the don't-care inputs.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // n counts edges from the accepting edge up to the one after which done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int saw_done;

        vecs[0]  = '{MD_OP_MUL, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{MD_OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2]  = '{MD_OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
        vecs[3]  = '{MD_OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[4]  = '{MD_OP_DIV, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[5]  = '{MD_OP_DIV, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 2};
        vecs[6]  = '{MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[7]  = '{MD_OP_MUL, 32'd0,        32'd12345,    32'h00000000, 32'h00000000, 1'b0, 34};
        vecs[8]  = '{MD_OP_DIV, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
        vecs[9]  = '{MD_OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34};
        vecs[10] = '{MD_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[11] = '{MD_OP_MUL, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
        vecs[12] = '{MD_OP_DIV, 32'd5,        32'd7,        32'h00000005, 32'h00000000, 1'b0, 34};
        vecs[13] = '{MD_OP_DIV, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 1'b0, 34};

        // Reset, with start held high to show clr wins.
        bus.start = 1'b1;
        bus.op    = MD_OP_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi",   64'(bus.result_hi), 64'd0);
        check("rst_lo",   64'(bus.result_lo), 64'd0);
        check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
        bus.start = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Each vector starts in the cycle where the previous done is high.
        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_after_accept", i), 64'(bus.busy), 64'd1);
            check($sformatf("v%0d_dbz_cleared", i), 64'(bus.div_by_zero), 64'd0);
            wait_done(n);
            check($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
            check($sformatf("v%0d_hi", i), 64'(bus.result_hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(bus.result_lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].exp_dbz));
        end

        // Start pulsed mid-operation is ignored and nothing is queued.
        launch(MD_OP_MUL, 32'd7, 32'hFFFFFFFD);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.op    = MD_OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        check("ign_latency", 64'(n + 5), 64'd34);
        check("ign_hi",  64'(bus.result_hi), 64'hFFFFFFFF);
        check("ign_lo",  64'(bus.result_lo), 64'hFFFFFFEB);
        check("ign_dbz", 64'(bus.div_by_zero), 64'd0);
        @(posedge clk);
        #1;
        check("ign_no_queue_busy", 64'(bus.busy), 64'd0);
        check("ign_done_drops",    64'(bus.done), 64'd0);

        // clr mid-operation aborts without done and zeroes outputs.
        launch(MD_OP_MUL, 32'd3, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_busy", 64'(bus.busy), 64'd0);
        check("clr_done", 64'(bus.done), 64'd0);
        check("clr_hi",   64'(bus.result_hi), 64'd0);
        check("clr_lo",   64'(bus.result_lo), 64'd0);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) saw_done++;
        end
        check("clr_no_done", 64'(saw_done), 64'd0);

        // Back-to-back: second start asserted in the done cycle.
        launch(MD_OP_MUL, 32'd6, 32'd9);
        wait_done(n);
        check("b2b_first_lo", 64'(bus.result_lo), 64'd54);
        launch(MD_OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("b2b_accepted", 64'(bus.busy), 64'd1);
        check("b2b_hold_lo",  64'(bus.result_lo), 64'd54);
        wait_done(n);
        check("b2b_latency", 64'(n), 64'd34);
        check("b2b_hi", 64'(bus.result_hi), 64'hFFFFFFFF);
        check("b2b_lo", 64'(bus.result_lo), 64'hFFFFFFFD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
